// File: rtl/paralelo_serial_pkg.sv
// Shared constants and state encoding for the parallel-to-serial link transmitter.
package paralelo_serial_pkg;

    localparam int          WORD_W     = 8;
    localparam int          CNT_W      = 3;
    localparam int          COM_CNT_W  = 3;
    localparam logic [7:0]  COM_SYM    = 8'hBC;
    localparam int          N_INIT_COM = 4;
    localparam int          FIFO_DEPTH = 2;

    typedef enum logic {
        ST_INIT   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    function automatic logic [WORD_W-1:0] shift_msb_first(input logic [WORD_W-1:0] sh);
        return {sh[WORD_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/paralelo_serial_if.sv
// Byte handshake in, serial bit stream plus framing/status out.
interface paralelo_serial_if;
    import paralelo_serial_pkg::*;

    logic [WORD_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic              data_out;
    logic              sync_out;
    logic              active_out;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  data_out,
        input  sync_out,
        input  active_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output data_out,
        output sync_out,
        output active_out
    );

endinterface

// File: rtl/paralelo_serial_fifo_ps.sv
// Small input FIFO; the head is visible combinationally so a word load can take it on the same edge.
module fifo_ps
    import paralelo_serial_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk32f,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [OCC_W-1:0] count_reg, count_next;
    logic             push_en;
    logic             pop_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_reg == OCC_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign dout    = mem[rd_ptr_reg];

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_en) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (pop_en) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        // simultaneous push and pop leaves occupancy unchanged
        unique case ({push_en, pop_en})
            2'b10:   count_next = count_reg + OCC_W'(1);
            2'b01:   count_next = count_reg - OCC_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk32f or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset: an empty count makes stale contents unreachable.
    always_ff @(posedge clk32f) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= din;
        end
    end

endmodule

// File: rtl/paralelo_serial.sv
// Parallel byte to MSB-first serial converter with COM-based link initialisation.
module paralelo_serial
    import paralelo_serial_pkg::*;
(
    input  logic             clk32f,
    input  logic             rst,
    paralelo_serial_if.slave ps
);

    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [WORD_W-1:0]    shift_reg, shift_next;
    logic                 sync_reg, sync_next;
    state_t               state_reg, state_next;
    logic [COM_CNT_W-1:0] com_cnt_reg, com_cnt_next;

    logic                 load;
    logic [WORD_W-1:0]    load_word;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [WORD_W-1:0]    fifo_head;

    assign load      = (cnt_reg == '0);
    assign fifo_push = ps.valid_in && !fifo_full;

    fifo_ps #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk32f (clk32f),
        .rst    (rst),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (ps.data_in),
        .dout   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Word selection and link state advance only on word boundaries.
    always_comb begin
        state_next   = state_reg;
        com_cnt_next = com_cnt_reg;
        fifo_pop     = 1'b0;
        load_word    = COM_SYM;
        if (load) begin
            unique case (state_reg)
                ST_INIT: begin
                    com_cnt_next = com_cnt_reg + COM_CNT_W'(1);
                    if (com_cnt_reg == COM_CNT_W'(N_INIT_COM - 1)) begin
                        state_next = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        load_word = fifo_head;
                    end
                end
                default: begin
                    state_next = ST_INIT;
                end
            endcase
        end
    end

    always_comb begin
        cnt_next   = cnt_reg + CNT_W'(1);
        sync_next  = load;
        shift_next = load ? load_word : shift_msb_first(shift_reg);
    end

    always_ff @(posedge clk32f or negedge rst) begin
        if (!rst) begin
            cnt_reg     <= '0;
            shift_reg   <= '0;
            sync_reg    <= 1'b0;
            state_reg   <= ST_INIT;
            com_cnt_reg <= '0;
        end else begin
            cnt_reg     <= cnt_next;
            shift_reg   <= shift_next;
            sync_reg    <= sync_next;
            state_reg   <= state_next;
            com_cnt_reg <= com_cnt_next;
        end
    end

    assign ps.data_out   = shift_reg[WORD_W-1];
    assign ps.sync_out   = sync_reg;
    assign ps.active_out = (state_reg == ST_ACTIVE);
    assign ps.ready_out  = !fifo_full;

endmodule

// File: tb/tb_paralelo_serial.sv
// Scoreboard bench: accepted bytes are queued, serial words are reassembled and compared.
module tb_paralelo_serial;
    import paralelo_serial_pkg::*;

    logic clk32f = 1'b0;
    logic rst    = 1'b0;

    paralelo_serial_if ps_bus ();

    paralelo_serial dut (
        .clk32f (clk32f),
        .rst    (rst),
        .ps     (ps_bus.slave)
    );

    always #5 clk32f = ~clk32f;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] word_hist[$];
    logic [7:0] mon_sh;
    int         mon_nbits;
    int         mon_gap;
    bit         mon_seen_sync;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic handle_word(input logic [7:0] w);
        int idx;
        idx = word_hist.size();
        word_hist.push_back(w);
        $display("word %0d = %02h", idx, w);
        if (idx < N_INIT_COM) begin
            check("init_com", w, COM_SYM);
        end else if (w != COM_SYM) begin
            if (exp_q.size() == 0) check("unexpected_word", w, COM_SYM);
            else                   check("data", w, exp_q.pop_front());
        end
    endtask

    // Deserialiser: a word starts on sync_out and closes after 8 bits.
    always @(negedge clk32f) begin
        if (!rst) begin
            exp_q.delete();
            word_hist.delete();
            mon_nbits     = 0;
            mon_gap       = 0;
            mon_seen_sync = 1'b0;
        end else begin
            mon_gap++;
            if (ps_bus.sync_out) begin
                if (mon_seen_sync) check("sync_gap", mon_gap, 8);
                mon_seen_sync = 1'b1;
                mon_gap       = 0;
                check("active", ps_bus.active_out, (word_hist.size() >= N_INIT_COM - 1));
                mon_sh    = {7'b0, ps_bus.data_out};
                mon_nbits = 1;
            end else if (mon_nbits > 0) begin
                mon_sh = {mon_sh[6:0], ps_bus.data_out};
                mon_nbits++;
            end
            if (mon_nbits == 8) begin
                handle_word(mon_sh);
                mon_nbits = 0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},   ps_bus.data_out,   1'b0);
        check({tag, "_sync"},   ps_bus.sync_out,   1'b0);
        check({tag, "_active"}, ps_bus.active_out, 1'b0);
        check({tag, "_ready"},  ps_bus.ready_out,  1'b1);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic offer(input logic [7:0] b);
        int tries;
        tries = 0;
        ps_bus.valid_in = 1'b1;
        ps_bus.data_in  = b;
        while (ps_bus.ready_out !== 1'b1 && tries < 40) begin
            @(negedge clk32f);
            tries++;
        end
        if (ps_bus.ready_out === 1'b1) begin
            exp_q.push_back(b);
            $display("push %02h", b);
        end else begin
            check("offer_timeout", tries, 0);
        end
        @(negedge clk32f);
        ps_bus.valid_in = 1'b0;
    endtask

    task automatic wait_sync();
        int t;
        t = 0;
        @(negedge clk32f);
        while (ps_bus.sync_out !== 1'b1 && t < 64) begin
            @(negedge clk32f);
            t++;
        end
        if (ps_bus.sync_out !== 1'b1) check("sync_timeout", ps_bus.sync_out, 1'b1);
    endtask

    task automatic wait_words(input int n);
        int t;
        t = 0;
        while (word_hist.size() < n && t < 400) begin
            @(posedge clk32f);
            t++;
        end
        check("word_wait", (word_hist.size() >= n), 1'b1);
    endtask

    function automatic logic [7:0] hist_at(input int i);
        return (i < word_hist.size()) ? word_hist[i] : 8'hXX;
    endfunction

    initial begin
        int cur;
        int t;
        ps_bus.valid_in = 1'b0;
        ps_bus.data_in  = 8'h00;
        rst = 1'b0;

        repeat (3) @(negedge clk32f);
        check_reset_outputs("por");

        // Bytes offered during initialisation are held behind the COM words.
        rst = 1'b1;
        offer(8'hFF);
        offer(8'h00);
        wait_words(7);
        check("init_hold_ff",  hist_at(4), 8'hFF);
        check("init_hold_00",  hist_at(5), 8'h00);
        check("init_hold_idle", hist_at(6), COM_SYM);

        // Single byte into an idle link takes the very next word slot.
        wait_sync();
        cur = word_hist.size();
        offer(8'hA5);
        wait_words(cur + 3);
        check("lat_a5",   hist_at(cur + 1), 8'hA5);
        check("after_a5", hist_at(cur + 2), COM_SYM);

        // Back-to-back offers: FIFO fills after two, third waits for a pop.
        wait_sync();
        cur = word_hist.size();
        offer(8'h01);
        offer(8'h02);
        ps_bus.valid_in = 1'b1;
        ps_bus.data_in  = 8'h03;
        check("ready_full", ps_bus.ready_out, 1'b0);
        offer(8'h03);
        wait_words(cur + 5);
        check("b2b_01",   hist_at(cur + 1), 8'h01);
        check("b2b_02",   hist_at(cur + 2), 8'h02);
        check("b2b_03",   hist_at(cur + 3), 8'h03);
        check("b2b_idle", hist_at(cur + 4), COM_SYM);

        // Mid-word reset with two bytes buffered: nothing survives.
        wait_sync();
        offer(8'h11);
        offer(8'h22);
        offer(8'h33);
        repeat (2) @(negedge clk32f);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk32f);
        rst = 1'b1;
        wait_words(6);
        check("rst_noreplay0", hist_at(4), COM_SYM);
        check("rst_noreplay1", hist_at(5), COM_SYM);

        // Random traffic, sparse then dense.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk32f);
            ps_bus.valid_in = ($urandom_range(0, (i < 5000) ? 11 : 2) == 0);
            ps_bus.data_in  = 8'($urandom);
            if (ps_bus.data_in == COM_SYM) ps_bus.data_in = 8'hBD;
            if (ps_bus.valid_in && ps_bus.ready_out) begin
                exp_q.push_back(ps_bus.data_in);
                $display("push %02h", ps_bus.data_in);
            end
        end
        @(negedge clk32f);
        ps_bus.valid_in = 1'b0;

        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk32f);
            t++;
        end
        check("drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
